mole_game_ctrl: RTL and testbench
=================================

# mole_game_ctrl

Round sequencer for the whack-a-mole game. It sits between the LFSR random source, the eight player buttons, the LED bank and the score display. It runs a fixed number of timed rounds. Each round it lights one mole LED chosen from the LFSR value and judges the player's press as hit or miss. It keeps the score shown on the seven-segment display.

## Interface
- ON_CYCLES, 50_000_000: maximum cycles a mole stays lit (1..2^32-1)
- GAP_CYCLES, 25_000_000: blank cycles before each mole (1..2^32-1)
- NUM_ROUNDS, 30: rounds per game (1..63)
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  level/pulse; starts a game when sampled high in IDLE or DONE
- rand_idx  in  3  LFSR output, sampled once per round
- button  in  8  player buttons, active-high, already synchronised to clk
- led  out  8  one-hot mole display (0 when no mole lit)
- score  out  6  hits this game, saturating at 63
- round_cnt  out  6  completed rounds this game
- busy  out  1  high in GAP and UP
- game_over  out  1  high in DONE
- hit  out  1  one-cycle pulse per hit
- miss  out  1  one-cycle pulse per miss

## Operation
- States: IDLE, GAP, UP, DONE. A 32-bit timer counts cycles within GAP and UP. `mole_idx` (3 bits) holds the lit position. `prev_idx` holds the last position used.
- Reset (reset==0 at a clk edge), from any state including mid-round:
  - state=IDLE; led=0, score=0, round_cnt=0, busy=0, game_over=0, hit=0, miss=0
  - timer=0, prev_idx=0, btn_prev=0
- Button edges: edge[i] = button[i] & ~btn_prev[i]. btn_prev is updated every cycle in every state, so a button already held at round start does not count.
- IDLE/DONE, start==1: go to GAP; clear score, round_cnt and timer.
- IDLE/DONE, start==0: stay. DONE holds score, round_cnt and game_over=1.
- start is ignored in GAP and UP.
- GAP: led=0. The timer counts. On the GAP_CYCLES-th cycle:
  - pick = rand_idx, or rand_idx+1 mod 8 if rand_idx==prev_idx (no repeat)
  - mole_idx=pick, prev_idx=pick
  - go to UP with timer=0
- UP: led = 1<<mole_idx. Each cycle, in priority order:
  - (a) any edge on a bit other than mole_idx: miss.
  - (b) otherwise, edge on bit mole_idx: hit.
  - (c) otherwise, if this is the ON_CYCLES-th UP cycle: miss (timeout).
  - (d) otherwise, stay in UP.
- A simultaneous correct and wrong press counts as a miss.
- Round end (hit or miss) takes effect at the next edge:
  - led=0, round_cnt+1
  - on hit: score+1, saturating at 63; hit=1 for one cycle
  - on miss: miss=1 for one cycle
  - next state: DONE if the new round_cnt==NUM_ROUNDS, else GAP with timer=0
- Edges in GAP, IDLE and DONE are ignored and never score.

## Timing
- start sampled at edge N: busy=1 and state GAP from N.
  - led becomes one-hot at edge N+GAP_CYCLES, i.e. the first UP cycle.
- With no press, UP lasts exactly ON_CYCLES cycles. led, miss and round_cnt update together at the edge after the last UP cycle.
- Press latency: edge present in UP cycle k → led=0, score and hit update at the next clk edge, one cycle later.
- The next mole appears GAP_CYCLES cycles after a round ends.
- game_over asserts in the same cycle as the final round's hit/miss pulse. busy drops in that cycle too.
- All outputs are registered. There are no combinational paths from input to output.

## Test plan
Overrides for all scenarios: ON_CYCLES=10, GAP_CYCLES=4, NUM_ROUNDS=3.
- Reset hold, then release with start=0 → all outputs 0; stays IDLE for 20 cycles.
- start pulse, rand_idx=5, correct press of button[5] on UP cycle 3:
  - led=8'h20 exactly 4 cycles after start
  - one cycle after the press: led=0, hit=1, score=1, round_cnt=1
- No press → led stays lit exactly 10 cycles, then miss=1, score unchanged.
  - Three such rounds → game_over=1, busy=0, round_cnt=3; score held afterwards.
- rand_idx held at 2 across rounds → moles at 2, then 3, then 2 (repeat avoidance).
- Press button[1] and button[mole_idx] in the same UP cycle → miss, score unchanged.
  - Holding a button through GAP into UP scores nothing.
- Reset asserted mid-UP with score=2 → next cycle all outputs 0, state IDLE.
  - start during UP is ignored.
  - start in DONE begins a new game with score=0.

Source files
------------

// File: rtl/mole_game_ctrl.sv
// Whack-a-mole round sequencer: runs NUM_ROUNDS timed rounds, lights one mole
// per round from the LFSR value, judges each press as hit or miss and keeps the
// score. All outputs are registered.
module mole_game_ctrl #(
  parameter int unsigned ON_CYCLES  = 50_000_000,
  parameter int unsigned GAP_CYCLES = 25_000_000,
  parameter int unsigned NUM_ROUNDS = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] rand_idx,
  input  logic [7:0] button,
  output logic [7:0] led,
  output logic [5:0] score,
  output logic [5:0] round_cnt,
  output logic       busy,
  output logic       game_over,
  output logic       hit,
  output logic       miss
);

  typedef enum logic [1:0] {StIdle, StGap, StUp, StDone} state_e;

  // Timer compares against the last cycle index of each phase.
  localparam logic [31:0] OnLast    = 32'(ON_CYCLES - 1);
  localparam logic [31:0] GapLast   = 32'(GAP_CYCLES - 1);
  localparam logic [5:0]  NumRounds = 6'(NUM_ROUNDS);
  localparam logic [5:0]  ScoreMax  = 6'd63;

  state_e      state_q, state_d;
  logic [31:0] timer_q, timer_d;
  logic [2:0]  mole_idx_q, mole_idx_d;
  logic [2:0]  prev_idx_q, prev_idx_d;
  logic [7:0]  btn_prev_q, btn_prev_d;
  logic [7:0]  led_q, led_d;
  logic [5:0]  score_q, score_d;
  logic [5:0]  round_cnt_q, round_cnt_d;
  logic        busy_q, busy_d;
  logic        game_over_q, game_over_d;
  logic        hit_q, hit_d;
  logic        miss_q, miss_d;

  logic [7:0]  btn_edge;
  logic [7:0]  mole_mask;
  logic        wrong_press;
  logic        right_press;
  logic [2:0]  pick;
  logic [5:0]  round_next;
  logic        end_round;
  logic        end_hit;

  // Next-state, round judging and registered-output updates.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    mole_idx_d  = mole_idx_q;
    prev_idx_d  = prev_idx_q;
    btn_prev_d  = button;
    led_d       = led_q;
    score_d     = score_q;
    round_cnt_d = round_cnt_q;
    busy_d      = busy_q;
    game_over_d = game_over_q;
    hit_d       = 1'b0;
    miss_d      = 1'b0;
    end_round   = 1'b0;
    end_hit     = 1'b0;

    btn_edge    = button & ~btn_prev_q;
    mole_mask   = 8'b1 << mole_idx_q;
    wrong_press = |(btn_edge & ~mole_mask);
    right_press = |(btn_edge & mole_mask);
    // Never light the same mole twice in a row.
    pick        = (rand_idx == prev_idx_q) ? rand_idx + 3'd1 : rand_idx;
    round_next  = round_cnt_q + 6'd1;

    case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StGap;
          score_d     = '0;
          round_cnt_d = '0;
          timer_d     = '0;
          led_d       = '0;
          busy_d      = 1'b1;
          game_over_d = 1'b0;
        end
      end
      StGap: begin
        if (timer_q == GapLast) begin
          state_d    = StUp;
          timer_d    = '0;
          mole_idx_d = pick;
          prev_idx_d = pick;
          led_d      = 8'b1 << pick;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      StUp: begin
        // A wrong press wins over a simultaneous correct one.
        if (wrong_press) begin
          end_round = 1'b1;
        end else if (right_press) begin
          end_round = 1'b1;
          end_hit   = 1'b1;
        end else if (timer_q == OnLast) begin
          end_round = 1'b1;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (end_round) begin
      led_d       = '0;
      round_cnt_d = round_next;
      if (end_hit) begin
        hit_d = 1'b1;
        if (score_q != ScoreMax) score_d = score_q + 6'd1;
      end else begin
        miss_d = 1'b1;
      end
      if (round_next == NumRounds) begin
        state_d     = StDone;
        busy_d      = 1'b0;
        game_over_d = 1'b1;
      end else begin
        state_d = StGap;
        timer_d = '0;
      end
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StIdle;
      timer_q     <= '0;
      mole_idx_q  <= '0;
      prev_idx_q  <= '0;
      btn_prev_q  <= '0;
      led_q       <= '0;
      score_q     <= '0;
      round_cnt_q <= '0;
      busy_q      <= 1'b0;
      game_over_q <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      mole_idx_q  <= mole_idx_d;
      prev_idx_q  <= prev_idx_d;
      btn_prev_q  <= btn_prev_d;
      led_q       <= led_d;
      score_q     <= score_d;
      round_cnt_q <= round_cnt_d;
      busy_q      <= busy_d;
      game_over_q <= game_over_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
    end
  end

  assign led       = led_q;
  assign score     = score_q;
  assign round_cnt = round_cnt_q;
  assign busy      = busy_q;
  assign game_over = game_over_q;
  assign hit       = hit_q;
  assign miss      = miss_q;

endmodule

// File: tb/tb_mole_game_ctrl.sv
// Directed bench for mole_game_ctrl with short timing (ON=10, GAP=4, 3 rounds).
module tb_mole_game_ctrl;

  logic       clk;
  logic       reset;
  logic       start;
  logic [2:0] rand_idx;
  logic [7:0] button;
  logic [7:0] led;
  logic [5:0] score;
  logic [5:0] round_cnt;
  logic       busy;
  logic       game_over;
  logic       hit;
  logic       miss;

  int n_checks = 0;
  int n_pass   = 0;

  mole_game_ctrl #(
    .ON_CYCLES (10),
    .GAP_CYCLES(4),
    .NUM_ROUNDS(3)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .rand_idx (rand_idx),
    .button   (button),
    .led      (led),
    .score    (score),
    .round_cnt(round_cnt),
    .busy     (busy),
    .game_over(game_over),
    .hit      (hit),
    .miss     (miss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance n clock edges, landing 1 time unit after the last rising edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_led"},  32'(led), 0);
    check({tag, "_score"}, 32'(score), 0);
    check({tag, "_rnd"},  32'(round_cnt), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_over"}, 32'(game_over), 0);
    check({tag, "_hit"},  32'(hit), 0);
    check({tag, "_miss"}, 32'(miss), 0);
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    rand_idx = 3'd0;
    button   = 8'h00;
    step(3);
    reset = 1'b1;
    step(1);
    check_all_zero("rst");
    step(20);
    check("idle20_busy", 32'(busy), 0);
    check("idle20_led",  32'(led), 0);

    // Game 1: round 1 correct press on UP cycle 3.
    rand_idx = 3'd5;
    start    = 1'b1;
    step(1);                       // start edge N
    start = 1'b0;
    check("g1_busy", 32'(busy), 1);
    check("g1_gap_led", 32'(led), 0);
    step(3);
    check("g1_led_n3", 32'(led), 0);
    step(1);                       // N+4, UP cycle 1
    check("g1_led_up", 32'(led), 32'h20);
    step(2);                       // UP cycle 3
    button = 8'h20;
    step(1);
    check("g1_hit_led",   32'(led), 0);
    check("g1_hit",       32'(hit), 1);
    check("g1_hit_score", 32'(score), 1);
    check("g1_hit_rnd",   32'(round_cnt), 1);
    button = 8'h00;
    step(1);
    check("g1_hit_pulse", 32'(hit), 0);

    // Round 2: rand repeats 5 -> mole 6, timeout after exactly 10 lit cycles.
    step(3);
    check("g1_r2_led", 32'(led), 32'h40);
    step(9);
    check("g1_r2_led10", 32'(led), 32'h40);
    check("g1_r2_nomiss", 32'(miss), 0);
    step(1);
    check("g1_r2_off",   32'(led), 0);
    check("g1_r2_miss",  32'(miss), 1);
    check("g1_r2_score", 32'(score), 1);
    check("g1_r2_rnd",   32'(round_cnt), 2);

    // Round 3: timeout ends the game.
    rand_idx = 3'd0;
    step(4);
    check("g1_r3_led", 32'(led), 32'h01);
    step(10);
    check("g1_r3_miss", 32'(miss), 1);
    check("g1_over",    32'(game_over), 1);
    check("g1_busy0",   32'(busy), 0);
    check("g1_rnd3",    32'(round_cnt), 3);
    check("g1_score",   32'(score), 1);
    step(5);
    check("g1_hold_over",  32'(game_over), 1);
    check("g1_hold_score", 32'(score), 1);
    check("g1_hold_rnd",   32'(round_cnt), 3);
    check("g1_hold_led",   32'(led), 0);

    // Game 2 from DONE, rand held at 2: moles 2, 3, 2.
    rand_idx = 3'd2;
    start    = 1'b1;
    step(1);
    start = 1'b0;
    check("g2_score0", 32'(score), 0);
    check("g2_rnd0",   32'(round_cnt), 0);
    check("g2_busy",   32'(busy), 1);
    check("g2_over0",  32'(game_over), 0);
    step(4);
    check("g2_r1_led", 32'(led), 32'h04);
    button = 8'h06;                // wrong and right together
    step(1);
    check("g2_both_led",   32'(led), 0);
    check("g2_both_miss",  32'(miss), 1);
    check("g2_both_hit",   32'(hit), 0);
    check("g2_both_score", 32'(score), 0);
    check("g2_both_rnd",   32'(round_cnt), 1);
    button = 8'h08;                // held from GAP into UP
    step(4);
    check("g2_r2_led", 32'(led), 32'h08);
    step(9);
    check("g2_held_led", 32'(led), 32'h08);
    check("g2_held_hit", 32'(hit), 0);
    step(1);
    check("g2_held_miss",  32'(miss), 1);
    check("g2_held_score", 32'(score), 0);
    check("g2_held_rnd",   32'(round_cnt), 2);
    button = 8'h00;
    step(4);
    check("g2_r3_led", 32'(led), 32'h04);
    start = 1'b1;                  // ignored in UP
    step(1);
    start = 1'b0;
    check("g2_upstart_led", 32'(led), 32'h04);
    check("g2_upstart_rnd", 32'(round_cnt), 2);
    button = 8'h04;
    step(1);
    button = 8'h00;
    check("g2_r3_hit",   32'(hit), 1);
    check("g2_r3_score", 32'(score), 1);
    check("g2_r3_rnd",   32'(round_cnt), 3);
    check("g2_r3_over",  32'(game_over), 1);
    check("g2_r3_busy",  32'(busy), 0);

    // Game 3: two hits, then reset in the middle of round 3.
    rand_idx = 3'd6;
    start    = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    check("g3_r1_led", 32'(led), 32'h40);
    button = 8'h40;
    step(1);
    button = 8'h00;
    check("g3_r1_score", 32'(score), 1);
    step(4);
    check("g3_r2_led", 32'(led), 32'h80);
    button = 8'h80;
    step(1);
    button = 8'h00;
    check("g3_r2_score", 32'(score), 2);
    step(4);
    check("g3_r3_led", 32'(led), 32'h40);
    step(2);
    reset = 1'b0;
    step(1);
    check_all_zero("midrst");
    reset = 1'b1;
    step(3);
    check("midrst_idle", 32'(busy), 0);

    // prev_idx was cleared by reset: rand 0 now steps to 1.
    rand_idx = 3'd0;
    start    = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    check("g4_led", 32'(led), 32'h02);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
